// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit seven-segment
// display. Rotates through the digits at CLK_DIV cycles per slot, blanking
// the anodes for BLANK_CYC cycles at the start of each slot. All outputs are
// registered and reflect the phase, digit and inputs of the previous cycle.
module seg_scan_ctrl #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] digit_mask,
   input  logic [6:0] seg0,
   input  logic [6:0] seg1,
   input  logic [6:0] seg2,
   input  logic [6:0] seg3,
   output logic [6:0] seg_out,
   output logic [3:0] anode_n,
   output logic [1:0] sel,
   output logic       slot_tick
);

   localparam int W = $clog2(CLK_DIV);
   localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } phase_t;

   phase_t       phase_reg, phase_next;
   logic [W-1:0] div_reg, div_next;
   logic [1:0]   sel_reg, sel_next;
   logic [6:0]   seg_reg, seg_next;
   logic [3:0]   anode_reg, anode_next;
   logic         tick_reg, tick_next;

   logic [6:0]   seg_arr [4];
   logic [3:0]   digit_hot;

   assign seg_arr[0] = seg0;
   assign seg_arr[1] = seg1;
   assign seg_arr[2] = seg2;
   assign seg_arr[3] = seg3;

   // One-hot decode of the current digit; inverted it becomes the anode drive,
   // so at most one anode can ever be low.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_hot
         assign digit_hot[gi] = (sel_reg == 2'(gi));
      end
   endgenerate

   // Next-state and next-output logic for the scan sequencer.
   always_comb begin
      phase_next = phase_reg;
      div_next   = div_reg;
      sel_next   = sel_reg;
      tick_next  = 1'b0;
      seg_next   = 7'h00;
      anode_next = 4'b1111;

      if (!en) begin
         // Park at digit 0 and stay dark until enabled again.
         phase_next = IDLE;
         div_next   = '0;
         sel_next   = 2'd0;
      end else begin
         if (phase_reg == IDLE) begin
            // Leaving IDLE counts as the start of slot 0.
            div_next  = '0;
            sel_next  = 2'd0;
            tick_next = 1'b1;
         end else if (div_reg == DIV_LAST) begin
            div_next  = '0;
            sel_next  = 2'(sel_reg + 2'd1);
            tick_next = 1'b1;
         end else begin
            div_next  = W'(div_reg + 1'b1);
         end

         phase_next = (int'(div_next) < BLANK_CYC) ? BLANK : SHOW;

         // Masked digits keep their slot but stay dark.
         if (phase_reg == SHOW && digit_mask[sel_reg]) begin
            seg_next   = seg_arr[sel_reg];
            anode_next = ~digit_hot;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_reg <= IDLE;
         div_reg   <= '0;
         sel_reg   <= 2'd0;
         seg_reg   <= 7'h00;
         anode_reg <= 4'b1111;
         tick_reg  <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         div_reg   <= div_next;
         sel_reg   <= sel_next;
         seg_reg   <= seg_next;
         anode_reg <= anode_next;
         tick_reg  <= tick_next;
      end
   end

   assign seg_out   = seg_reg;
   assign anode_n   = anode_reg;
   assign sel       = sel_reg;
   assign slot_tick = tick_reg;

endmodule
